// File: rtl/coin_pkg.sv
// Shared constants and types for the coin datapath: screen geometry,
// coordinate/colour widths, colour codes and the mover FSM state encoding.
package coin_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  localparam int X_W = 8;
  localparam int Y_W = 7;
  localparam int C_W = 3;

  localparam logic [C_W-1:0] COIN_YELLOW = 3'b110;
  localparam logic [C_W-1:0] BG_BLACK    = 3'b000;

  typedef enum logic [1:0] {
    IDLE,
    ERASE,
    MOVE,
    DRAW
  } coin_state_t;

endpackage

// File: rtl/coin_lfsr.sv
// 8-bit Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1, loaded with SEED on
// reset and advanced whenever en is high. Used for the random respawn column.
module coin_lfsr #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       en,
  output logic [7:0] q
);

  // Shift left, feedback from taps 8,6,5,4 enters at bit 0.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      q <= SEED;
    end else if (en) begin
      q <= {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
    end
  end

endmodule

// File: rtl/coin_mover.sv
// Falling-coin animator. On each plot_en frame tick it erases the coin,
// advances it STEP rows (respawning at the top when collected or when it
// would leave the screen), then redraws it, one VGA pixel write per cycle.
// Optional build macro: COIN_RANDOM_X_EN selects an LFSR-driven respawn
// column instead of the fixed X_START column.
module coin_mover
  import coin_pkg::*;
#(
  parameter int             COIN_SIZE   = 4,
  parameter int             STEP        = 1,
  parameter int             X_START     = 78,
  parameter logic [C_W-1:0] COIN_COLOUR = COIN_YELLOW,
  parameter logic [C_W-1:0] BG_COLOUR   = BG_BLACK
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           plot_en,
  input  logic           collected,
  output logic [X_W-1:0] vga_x,
  output logic [Y_W-1:0] vga_y,
  output logic [C_W-1:0] vga_colour,
  output logic           vga_plot,
  output logic [X_W-1:0] coin_x,
  output logic [Y_W-1:0] coin_y,
  output logic           busy,
  output logic           miss
);

  localparam int N       = COIN_SIZE * COIN_SIZE;
  localparam int CS_W    = $clog2(COIN_SIZE);
  localparam int CNT_W   = $clog2(N) + 1;
  localparam int Y_LIMIT = SCREEN_H - COIN_SIZE;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  coin_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pending_q, pending_d;
  logic             collected_flag_q, collected_flag_d;

  logic [X_W-1:0]   vga_x_d, coin_x_d, respawn_x;
  logic [Y_W-1:0]   vga_y_d, coin_y_d;
  logic [C_W-1:0]   vga_colour_d;
  logic             vga_plot_d, busy_d, miss_d;

  // Pixel offset inside the coin square: low bits are column, next bits row.
  logic [CS_W-1:0]  pix_col, pix_row;
  assign pix_col = cnt_q[CS_W-1:0];
  assign pix_row = cnt_q[2*CS_W-1:CS_W];

`ifdef COIN_RANDOM_X_EN
  localparam int XMAX = SCREEN_W - COIN_SIZE;

  logic [7:0] lfsr_q;

  coin_lfsr #(
    .SEED (8'hA5)
  ) u_lfsr (
    .clk    (clk),
    .resetn (resetn),
    .en     (1'b1),
    .q      (lfsr_q)
  );

  // Fold out-of-range LFSR values back into 0..XMAX.
  always_comb begin
    if (lfsr_q <= X_W'(XMAX)) respawn_x = lfsr_q;
    else                      respawn_x = lfsr_q - X_W'(XMAX + 1);
  end
`else
  assign respawn_x = X_W'(X_START);
`endif

  // Next-state and next-output logic for the erase/move/draw sequence.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path can
    // leave one unassigned and infer a latch.
    state_d          = state_q;
    cnt_d            = cnt_q;
    pending_d        = pending_q;
    collected_flag_d = collected_flag_q | collected;
    coin_x_d         = coin_x;
    coin_y_d         = coin_y;
    vga_x_d          = vga_x;
    vga_y_d          = vga_y;
    vga_colour_d     = vga_colour;
    vga_plot_d       = 1'b0;
    miss_d           = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (plot_en || pending_q) begin
          state_d   = ERASE;
          pending_d = 1'b0;
          cnt_d     = '0;
        end
      end

      ERASE, DRAW: begin
        if (plot_en) pending_d = 1'b1;
        vga_plot_d   = 1'b1;
        vga_x_d      = coin_x + X_W'(pix_col);
        vga_y_d      = coin_y + Y_W'(pix_row);
        vga_colour_d = (state_q == ERASE) ? BG_COLOUR : COIN_COLOUR;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = (state_q == ERASE) ? MOVE : IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      MOVE: begin
        if (plot_en) pending_d = 1'b1;
        // The flag is consumed here; a pulse arriving this cycle is kept.
        collected_flag_d = collected;
        if (collected_flag_q) begin
          coin_x_d = respawn_x;
          coin_y_d = '0;
        end else if ((int'(coin_y) + STEP) > Y_LIMIT) begin
          coin_x_d = respawn_x;
          coin_y_d = '0;
          miss_d   = 1'b1;
        end else begin
          coin_y_d = coin_y + Y_W'(STEP);
        end
        cnt_d   = '0;
        state_d = DRAW;
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and registered-output update with synchronous reset priority.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!resetn) begin
      state_q          <= IDLE;
      cnt_q            <= '0;
      pending_q        <= 1'b0;
      collected_flag_q <= 1'b0;
      coin_x           <= X_W'(X_START);
      coin_y           <= '0;
      vga_x            <= '0;
      vga_y            <= '0;
      vga_colour       <= '0;
      vga_plot         <= 1'b0;
      busy             <= 1'b0;
      miss             <= 1'b0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      pending_q        <= pending_d;
      collected_flag_q <= collected_flag_d;
      coin_x           <= coin_x_d;
      coin_y           <= coin_y_d;
      vga_x            <= vga_x_d;
      vga_y            <= vga_y_d;
      vga_colour       <= vga_colour_d;
      vga_plot         <= vga_plot_d;
      busy             <= busy_d;
      miss             <= miss_d;
    end
  end

endmodule

// File: tb/tb_coin_mover.sv
// Directed self-checking bench for coin_mover (default parameters).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_coin_mover;

  logic       clk = 1'b0;
  logic       resetn;
  logic       plot_en;
  logic       collected;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;
  logic [7:0] coin_x;
  logic [6:0] coin_y;
  logic       busy;
  logic       miss;

  int checks = 0;
  int errors = 0;
  bit x_known = 1'b1;   // respawn column is predictable only without the LFSR

  coin_mover dut (
    .clk        (clk),
    .resetn     (resetn),
    .plot_en    (plot_en),
    .collected  (collected),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot),
    .coin_x     (coin_x),
    .coin_y     (coin_y),
    .busy       (busy),
    .miss       (miss)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One plot_en tick and the full erase/move/draw sequence it triggers.
  // ey: row the coin is erased at, dy: row it is redrawn at.
  task automatic frame(input string tag, input int ey, input int dy,
                       input bit exp_miss, input bit inj_col);
    int i, busy_n, plot_n, miss_n, first_plot, k, yb, ex, gx;
    logic [17:0] e, g;
    busy_n = 0; plot_n = 0; miss_n = 0; first_plot = -1;
    plot_en = 1'b1;
    @(negedge clk);
    plot_en = 1'b0;
    i = 0;
    while ((busy || vga_plot) && i < 100) begin
      collected = inj_col && (i == 3);
      if (busy) busy_n++;
      if (miss) miss_n++;
      if (vga_plot) begin
        if (first_plot < 0) first_plot = i;
        k  = plot_n % 16;
        yb = (plot_n < 16) ? ey : dy;
        ex = x_known ? 78 + k % 4 : 0;
        gx = x_known ? int'(vga_x) : 0;
        e  = {8'(ex), 7'(yb + k / 4), (plot_n < 16) ? 3'b000 : 3'b110};
        g  = {8'(gx), vga_y, vga_colour};
        check({tag, (plot_n < 16) ? "_erase_px" : "_draw_px"}, 32'(g), 32'(e));
        plot_n++;
      end
      @(negedge clk);
      i++;
    end
    collected = 1'b0;
    check({tag, "_done"}, 32'(i < 100), 32'd1);
    check({tag, "_plots"}, 32'(plot_n), 32'd32);
    check({tag, "_busy_cycles"}, 32'(busy_n), 32'd33);
    check({tag, "_first_plot"}, 32'(first_plot), 32'd1);
    check({tag, "_miss"}, 32'(miss_n), 32'(exp_miss));
    check({tag, "_coin_y"}, 32'(coin_y), 32'(dy));
    if (x_known) check({tag, "_coin_x"}, 32'(coin_x), 32'd78);
  endtask

  initial begin : main
    int i, busy_n, plot_n, bad;
    bit seen [256];

    resetn = 1'b0; plot_en = 1'b0; collected = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_coin_x", 32'(coin_x), 32'd78);
    check("rst_coin_y", 32'(coin_y), 32'd0);
    check("rst_vga", 32'({vga_x, vga_y, vga_colour}), 32'd0);
    check("rst_plot_busy_miss", 32'({vga_plot, busy, miss}), 32'd0);
    resetn = 1'b1;

    // Idle: nothing may happen without a tick.
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy || vga_plot || miss) bad++;
    end
    check("idle_quiet", 32'(bad), 32'd0);
    check("idle_coin_x", 32'(coin_x), 32'd78);
    check("idle_coin_y", 32'(coin_y), 32'd0);

    frame("first", 0, 1, 1'b0, 1'b0);

    // Walk down to the last legal row, then fall off the bottom.
    for (int y = 1; y < 116; y++) frame("walk", y, y + 1, 1'b0, 1'b0);
    frame("bottom", 116, 0, 1'b1, 1'b0);

    // Collected during ERASE at row 50: respawn without miss, flag then clear.
    for (int y = 0; y < 50; y++) frame("walk2", y, y + 1, 1'b0, 1'b0);
    frame("collect", 50, 0, 1'b0, 1'b1);
`ifdef COIN_RANDOM_X_EN
    x_known = 1'b0;
`endif
    frame("after_collect", 0, 1, 1'b0, 1'b0);

    // Two extra ticks in one busy window: exactly one queued sequence.
    busy_n = 0; plot_n = 0;
    plot_en = 1'b1;
    @(negedge clk);
    plot_en = 1'b0;
    i = 0;
    while ((busy || vga_plot) && i < 200) begin
      plot_en = (i == 5) || (i == 20);
      if (busy) busy_n++;
      if (vga_plot) plot_n++;
      @(negedge clk);
      i++;
    end
    plot_en = 1'b0;
    check("pend_done", 32'(i < 200), 32'd1);
    check("pend_plots", 32'(plot_n), 32'd64);
    check("pend_busy_cycles", 32'(busy_n), 32'd66);
    check("pend_coin_y", 32'(coin_y), 32'd3);
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (busy || vga_plot) bad++;
    end
    check("pend_no_third", 32'(bad), 32'd0);

    // Reset in the middle of DRAW aborts at the next edge.
    plot_en = 1'b1;
    @(negedge clk);
    plot_en = 1'b0;
    repeat (24) @(negedge clk);
    check("middraw_plot", 32'(vga_plot), 32'd1);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    check("middraw_rst_plot", 32'(vga_plot), 32'd0);
    check("middraw_rst_busy", 32'(busy), 32'd0);
    check("middraw_rst_coin_x", 32'(coin_x), 32'd78);
    check("middraw_rst_coin_y", 32'(coin_y), 32'd0);
    x_known = 1'b1;
    frame("post_rst", 0, 1, 1'b0, 1'b0);

`ifdef COIN_RANDOM_X_EN
    x_known = 1'b0;
    bad = 0;
    for (int r = 0; r < 50; r++) begin
      frame("rand", (r == 0) ? 1 : 0, 0, 1'b0, 1'b1);
      check("rand_x_range", 32'(coin_x <= 8'd156), 32'd1);
      if (!seen[coin_x]) begin
        seen[coin_x] = 1'b1;
        bad++;
      end
    end
    check("rand_x_distinct", 32'(bad >= 10), 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/coin_mover.md
Name: coin_mover

Overview:
- Sits directly downstream of the frame counter in the coin datapath.
- Consumes the one-cycle plot_en frame tick and animates one falling coin on the 160x120 VGA framebuffer.
- Per tick: erases the coin at its old position, advances it by STEP rows, then redraws it.
- Drives the VGA adapter write port one pixel per cycle.
- Handles respawn at the top when the coin is collected or leaves the screen bottom.

Parameters:
- SCREEN_W, 160, framebuffer width in pixels
- SCREEN_H, 120, framebuffer height in pixels
- COIN_SIZE, 4, coin edge length in pixels; power of 2, 2..8
- STEP, 1, rows moved per plot_en tick; 1..8
- X_START, 78, coin x after reset and fixed respawn column
- COIN_COLOUR, 3'b110, draw colour (yellow)
- BG_COLOUR, 3'b000, erase colour

Ports:
- clk  in  1  system clock
- resetn  in  1  synchronous active-low reset
- plot_en  in  1  frame tick from the frame counter; one-cycle pulse
- collected  in  1  pulse from collision logic: player touched the coin
- vga_x  out  8  pixel x to the VGA adapter
- vga_y  out  7  pixel y to the VGA adapter
- vga_colour  out  3  pixel colour
- vga_plot  out  1  pixel write strobe
- coin_x  out  8  current coin top-left x
- coin_y  out  7  current coin top-left y
- busy  out  1  high whenever state is not IDLE
- miss  out  1  one-cycle pulse when the coin leaves the bottom uncollected

Behaviour:
- Clocking and reset: one clock. Reset is synchronous and active-low, checked every clk edge, and has priority over all other logic. A reset mid-operation aborts at the next edge.
- Reset values: coin_x=X_START, coin_y=0, vga_x=0, vga_y=0, vga_colour=0, vga_plot=0, busy=0, miss=0. State=IDLE, pending=0, collected_flag=0, pixel counter=0.
- Registered outputs: all outputs are registered.
- FSM states: IDLE, ERASE, MOVE, DRAW.
- IDLE:
  - if plot_en or pending, go to ERASE, clear pending, and set cnt=0.
  - else stay in IDLE.
- ERASE:
  - each cycle: vga_plot=1, vga_x=coin_x+cnt%COIN_SIZE, vga_y=coin_y+cnt/COIN_SIZE, vga_colour=BG_COLOUR.
  - after N=COIN_SIZE^2 pixels, go to MOVE.
- MOVE (one cycle, vga_plot=0):
  - if collected_flag, respawn.
  - else if coin_y+STEP > SCREEN_H-COIN_SIZE, respawn and pulse miss=1 for this cycle.
  - else coin_y += STEP.
  - respawn means coin_y=0, coin_x=respawn column, and clear collected_flag.
- DRAW: same as ERASE with COIN_COLOUR at the updated position; after N pixels, return to IDLE.
- Timing: the first vga_plot is high on the 2nd edge after plot_en is sampled. busy stays high for 2N+1 cycles after leaving IDLE.
- plot_en while busy: sets pending (one-deep). Further ticks while pending=1 are dropped.
- collected: latched into sticky collected_flag on any cycle, including IDLE. It is consumed only in MOVE.
- Simultaneous collected and bottom in MOVE: collected wins, no miss.
- Arithmetic: pixel address sums never exceed the screen, guaranteed by the clamp. cnt is $clog2(N)+1 bits wide. Widths are truncated to port width.

Optional Feature:
- Macro: COIN_RANDOM_X_EN.
- Defined:
  - respawn column comes from an 8-bit Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1, seed 8'hA5 on reset, advancing every clk.
  - XMAX=SCREEN_W-COIN_SIZE; x = lfsr if lfsr<=XMAX, else lfsr-XMAX-1.
- Undefined: respawn column is always X_START and no LFSR is synthesised.

Decomposition:
- Package coin_pkg holds:
  - the screen dimensions
  - coordinate width constants (X_W=8, Y_W=7, C_W=3)
  - colour constants
  - the FSM state enum
- Sub-module coin_lfsr (8-bit LFSR with seed and enable), instantiated only under COIN_RANDOM_X_EN.

Test Plan:
- Reset, then 20 idle cycles: coin_x=78, coin_y=0, vga_plot=0, busy=0.
- Single plot_en from reset:
  - 16 erase writes, colour 0, covering (78..81, 0..3);
  - then 16 writes, colour 3'b110, covering (78..81, 1..4);
  - busy high 33 cycles; coin_y=1.
- Step to coin_y=116, then plot_en: respawn coin_y=0, miss high exactly 1 cycle, draw at y 0..3.
- collected pulse during ERASE at coin_y=50: respawn to y=0 with no miss; collected_flag cleared.
- Two plot_en pulses during one busy window: exactly one extra erase/move/draw sequence follows, and coin_y advances by 2 total.
- resetn low for one cycle mid-DRAW: next edge gives vga_plot=0, coin_x=78, coin_y=0, state IDLE.
- With COIN_RANDOM_X_EN, 50 respawns: all coin_x in 0..156, and at least 10 distinct values.
